// File: rtl/udp_axis_pkg.sv
// Shared types and constants for the UDP <-> AXI-Stream bridge blocks.
package udp_axis_pkg;

    typedef enum logic [1:0] {
        STATE_FILL,
        STATE_TX_HEADER,
        STATE_TX_ID,
        STATE_TX_PAYLOAD
    } state_t;

    localparam int UDP_HDR_BYTES   = 8;
    localparam int PACKET_ID_BYTES = 4;

    // Number of set bits in a byte-enable mask (up to 8 lanes).
    function automatic logic [3:0] keep_count(input logic [7:0] keep);
        logic [3:0] cnt;
        cnt = '0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + 4'(keep[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/udp_axis_slave_if.sv
// Stream and UDP TX header interfaces used by the UDP transmitter.
interface axis_if #(
    parameter int DATA_W = 8,
    parameter int KEEP_W = 1,
    parameter int USER_W = 1
);
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [USER_W-1:0] tuser;

    modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

interface udp_tx_hdr_if;
    logic        valid;
    logic        ready;
    logic [31:0] dest_ip;
    logic [15:0] source_port;
    logic [15:0] dest_port;
    logic [15:0] length;
    logic [15:0] checksum;

    modport master (output valid, dest_ip, source_port, dest_port, length, checksum, input ready);
    modport slave  (input valid, dest_ip, source_port, dest_port, length, checksum, output ready);
endinterface

// File: rtl/udp_axis_slave_buffer.sv
// Byte-wide frame buffer: multi-lane packed write, single registered read port.
module udp_axis_slave_buffer #(
    parameter int LANES = 4,
    parameter int DEPTH = 1024,
    parameter int AW    = 10,
    parameter int CW    = 11
) (
    input  logic               clk,
    input  logic [LANES-1:0]   we_i,
    input  logic [CW-1:0]      waddr_i,
    input  logic [8*LANES-1:0] wdata_i,
    input  logic [AW-1:0]      raddr_i,
    output logic [7:0]         rdata_o
);
    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;

    // Lane l lands at waddr+l; bytes past the end of the buffer are dropped.
    always_ff @(posedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            if (we_i[l] && ((int'(waddr_i) + l) < DEPTH)) begin
                mem_q[AW'(int'(waddr_i) + l)] <= wdata_i[8*l +: 8];
            end
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/udp_axis_slave.sv
// AXI-Stream to UDP transmitter: buffers one frame, then sends header,
// 4-byte big-endian packet ID and the buffered bytes as one datagram.
//
// state            | meaning
// STATE_FILL       | accepting input beats into the buffer
// STATE_TX_HEADER  | UDP header offered, waiting for ready
// STATE_TX_ID      | sending the 4 packet ID bytes, MSB first
// STATE_TX_PAYLOAD | streaming buffered bytes, tlast on the final one
module udp_axis_slave
    import udp_axis_pkg::*;
#(
    parameter int          UDP_SOURCE_PORT     = 8891,
    parameter int          UDP_DEST_PORT       = 4321,
    parameter logic [31:0] DEST_IP             = 32'hC0A8_0164,
    parameter int          AXIS_IN_TDATA_WIDTH = 32,
    parameter int          MAX_PAYLOAD_BYTES   = 1024
) (
    input  logic         clk,
    input  logic         reset_n,
    axis_if.slave        in_axis_if,
    udp_tx_hdr_if.master udp_tx_header_if,
    axis_if.master       udp_tx_payload_if
);
    localparam int            LANES = AXIS_IN_TDATA_WIDTH / 8;
    localparam int            AW    = $clog2(MAX_PAYLOAD_BYTES);
    localparam int            CW    = $clog2(MAX_PAYLOAD_BYTES + 1);
    localparam logic [CW-1:0] MAX_N = CW'(MAX_PAYLOAD_BYTES);

    state_t        state_q, state_d;
    logic [CW-1:0] n_q, n_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [1:0]    id_idx_q, id_idx_d;
    logic [31:0]   packet_id_q, packet_id_d;
    logic          bad_q, bad_d;

    logic             in_fire, hdr_fire, pay_fire, pay_last;
    logic             beat_bad, frame_full;
    logic [3:0]       beat_bytes;
    logic [CW:0]      n_sum;
    logic [LANES-1:0] ram_we;
    logic [7:0]       ram_rdata;
    logic [7:0]       id_byte;

    assign in_fire    = in_axis_if.tvalid && (state_q == STATE_FILL);
    assign hdr_fire   = (state_q == STATE_TX_HEADER) && udp_tx_header_if.ready;
    assign pay_fire   = ((state_q == STATE_TX_ID) || (state_q == STATE_TX_PAYLOAD))
                        && udp_tx_payload_if.tready;
    assign beat_bytes = keep_count(8'(in_axis_if.tkeep));
    assign n_sum      = {1'b0, n_q} + (CW+1)'(beat_bytes);
    // With lane-aligned beats the count lands exactly on the buffer size.
    assign frame_full = n_sum >= {1'b0, MAX_N};
    assign beat_bad   = bad_q || in_axis_if.tuser[0];
    assign ram_we     = in_fire ? in_axis_if.tkeep : '0;
    assign id_byte    = 8'(packet_id_q >> {(2'd3 - id_idx_q), 3'b000});
    assign pay_last   = ((state_q == STATE_TX_ID) && (id_idx_q == 2'd3) && (n_q == '0))
                     || ((state_q == STATE_TX_PAYLOAD) && ((CW'(rd_ptr_q) + CW'(1)) == n_q));

    // Read address follows the next pointer so the RAM output always holds
    // the byte at rd_ptr_q: one byte per clock with no bubble.
    udp_axis_slave_buffer #(
        .LANES (LANES),
        .DEPTH (MAX_PAYLOAD_BYTES),
        .AW    (AW),
        .CW    (CW)
    ) u_buffer (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (n_q),
        .wdata_i (in_axis_if.tdata),
        .raddr_i (rd_ptr_d),
        .rdata_o (ram_rdata)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= STATE_FILL;
            n_q         <= '0;
            rd_ptr_q    <= '0;
            id_idx_q    <= '0;
            packet_id_q <= '0;
            bad_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            rd_ptr_q    <= rd_ptr_d;
            id_idx_q    <= id_idx_d;
            packet_id_q <= packet_id_d;
            bad_q       <= bad_d;
        end
    end

    // Next-state and counter updates.
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        rd_ptr_d    = rd_ptr_q;
        id_idx_d    = id_idx_q;
        packet_id_d = packet_id_q;
        bad_d       = bad_q;
        unique case (state_q)
            STATE_FILL: begin
                if (in_fire) begin
                    if (in_axis_if.tlast || frame_full) begin
                        bad_d = 1'b0;
                        if (beat_bad) begin
                            n_d = '0;
                        end else begin
                            n_d     = frame_full ? MAX_N : n_sum[CW-1:0];
                            state_d = STATE_TX_HEADER;
                        end
                    end else begin
                        n_d   = n_sum[CW-1:0];
                        bad_d = beat_bad;
                    end
                end
            end
            STATE_TX_HEADER: begin
                if (hdr_fire) begin
                    state_d  = STATE_TX_ID;
                    id_idx_d = '0;
                end
            end
            STATE_TX_ID: begin
                if (pay_fire) begin
                    if (id_idx_q == 2'd3) begin
                        state_d = STATE_TX_PAYLOAD;
                    end else begin
                        id_idx_d = id_idx_q + 2'd1;
                    end
                end
            end
            STATE_TX_PAYLOAD: begin
                if (pay_fire) begin
                    rd_ptr_d = rd_ptr_q + AW'(1);
                end
            end
            default: state_d = STATE_FILL;
        endcase
        if (pay_fire && pay_last) begin
            state_d     = STATE_FILL;
            n_d         = '0;
            rd_ptr_d    = '0;
            packet_id_d = packet_id_q + 32'd1;
        end
    end

    // Interface outputs decoded from the registered state.
    always_comb begin
        in_axis_if.tready            = (state_q == STATE_FILL);
        udp_tx_header_if.valid       = 1'b0;
        udp_tx_header_if.dest_ip     = '0;
        udp_tx_header_if.source_port = '0;
        udp_tx_header_if.dest_port   = '0;
        udp_tx_header_if.length      = '0;
        udp_tx_header_if.checksum    = '0;
        if (state_q == STATE_TX_HEADER) begin
            udp_tx_header_if.valid       = 1'b1;
            udp_tx_header_if.dest_ip     = DEST_IP;
            udp_tx_header_if.source_port = 16'(UDP_SOURCE_PORT);
            udp_tx_header_if.dest_port   = 16'(UDP_DEST_PORT);
            udp_tx_header_if.length      = 16'(UDP_HDR_BYTES + PACKET_ID_BYTES) + 16'(n_q);
        end
        udp_tx_payload_if.tvalid = (state_q == STATE_TX_ID) || (state_q == STATE_TX_PAYLOAD);
        udp_tx_payload_if.tdata  = '0;
        if (state_q == STATE_TX_ID) begin
            udp_tx_payload_if.tdata = id_byte;
        end else if (state_q == STATE_TX_PAYLOAD) begin
            udp_tx_payload_if.tdata = ram_rdata;
        end
        udp_tx_payload_if.tlast = pay_last;
        udp_tx_payload_if.tuser = '0;
        udp_tx_payload_if.tkeep = '1;
    end
endmodule

// File: tb/tb_udp_axis_slave.sv
// Directed bench for the AXI-Stream to UDP transmitter.
module tb_udp_axis_slave;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    axis_if #(.DATA_W(32), .KEEP_W(4), .USER_W(1)) in_if ();
    udp_tx_hdr_if                                  hdr_if ();
    axis_if #(.DATA_W(8), .KEEP_W(1), .USER_W(1))  pay_if ();

    udp_axis_slave #(
        .UDP_SOURCE_PORT     (8891),
        .UDP_DEST_PORT       (4321),
        .DEST_IP             (32'hC0A8_0164),
        .AXIS_IN_TDATA_WIDTH (32),
        .MAX_PAYLOAD_BYTES   (1024)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .in_axis_if        (in_if),
        .udp_tx_header_if  (hdr_if),
        .udp_tx_payload_if (pay_if)
    );

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        logic        u;
    } beat_t;

    int tests_run    = 0;
    int tests_failed = 0;

    beat_t       tx_q[$];
    logic [7:0]  e_bytes[$];
    logic [7:0]  r_bytes[$];
    logic [7:0]  q1_bytes[$];
    logic [15:0] r_len, r_sp, r_dp, r_cs, len1;
    logic [31:0] r_ip;
    int          r_unstable, r_gap, r_span, r_inrdy, r_tuser;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add_beat(input logic [31:0] d, input logic [3:0] k, input logic l, input logic u);
        beat_t b;
        b.d = d; b.k = k; b.l = l; b.u = u;
        tx_q.push_back(b);
    endtask

    task automatic frame_a();
        tx_q.delete();
        add_beat(32'h0403_0201, 4'hF, 1'b0, 1'b0);
        add_beat(32'h0807_0605, 4'hF, 1'b1, 1'b0);
    endtask

    task automatic exp_id(input logic [31:0] id);
        e_bytes.delete();
        for (int i = 0; i < 4; i++) e_bytes.push_back(id[31-8*i -: 8]);
    endtask

    task automatic exp_a(input logic [31:0] id);
        exp_id(id);
        for (int i = 1; i <= 8; i++) e_bytes.push_back(8'(i));
    endtask

    task automatic check_payload(input string tag, input logic [7:0] got[$]);
        int mism = 0;
        check({tag, "_size"}, got.size(), e_bytes.size());
        for (int i = 0; i < got.size() && i < e_bytes.size(); i++) begin
            if (got[i] !== e_bytes[i]) mism++;
        end
        check({tag, "_bytes_wrong"}, mism, 0);
    endtask

    // Called at a negedge; returns at the negedge after the last transfer.
    task automatic send();
        int cyc;
        bit rdy;
        foreach (tx_q[i]) begin
            in_if.tdata  = tx_q[i].d;
            in_if.tkeep  = tx_q[i].k;
            in_if.tlast  = tx_q[i].l;
            in_if.tuser  = tx_q[i].u;
            in_if.tvalid = 1'b1;
            cyc = 0;
            do begin
                rdy = in_if.tready;
                @(negedge clk);
                cyc++;
            end while (!rdy && cyc < 4000);
            if (!rdy) begin
                check("in_tready_timeout", rdy, 1);
                break;
            end
        end
        in_if.tvalid = 1'b0;
        in_if.tlast  = 1'b0;
        in_if.tuser  = 1'b0;
    endtask

    // Receives one datagram; header ready held low for hdr_delay cycles,
    // payload ready alternating 1/0 when toggle is set.
    task automatic recv(input int hdr_delay, input bit toggle);
        int cyc;
        int k;
        bit done;
        r_bytes.delete();
        r_unstable = 0; r_gap = 0; r_span = 0; r_inrdy = 0; r_tuser = 0;
        hdr_if.ready  = 1'b0;
        pay_if.tready = 1'b0;
        cyc = 0;
        @(negedge clk);
        while (!hdr_if.valid && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        if (!hdr_if.valid) begin
            check("hdr_valid_timeout", hdr_if.valid, 1);
            return;
        end
        r_len = hdr_if.length; r_sp = hdr_if.source_port; r_dp = hdr_if.dest_port;
        r_ip  = hdr_if.dest_ip; r_cs = hdr_if.checksum;
        for (int d = 0; d < hdr_delay; d++) begin
            @(negedge clk);
            if (!hdr_if.valid || hdr_if.length !== r_len || hdr_if.source_port !== r_sp
                || hdr_if.dest_port !== r_dp || hdr_if.dest_ip !== r_ip || hdr_if.checksum !== r_cs)
                r_unstable++;
            if (in_if.tready) r_inrdy++;
        end
        hdr_if.ready = 1'b1;
        @(negedge clk);
        hdr_if.ready = 1'b0;
        done = 1'b0; k = 0; cyc = 0;
        while (!done && cyc < 8000) begin
            pay_if.tready = toggle ? (k % 2 == 0) : 1'b1;
            cyc++;
            if (in_if.tready) r_inrdy++;
            if (pay_if.tvalid) begin
                if (r_gap == 0) r_gap = cyc;
                if (pay_if.tuser !== 1'b0) r_tuser++;
                if (pay_if.tready) begin
                    r_bytes.push_back(pay_if.tdata);
                    if (pay_if.tlast) begin
                        done = 1'b1;
                        r_span = cyc - r_gap + 1;
                    end
                end
            end
            k++;
            @(negedge clk);
        end
        pay_if.tready = 1'b0;
        if (!done) check("pay_tlast_timeout", done, 1);
    endtask

    initial begin
        int hv;
        reset_n       = 1'b0;
        in_if.tvalid  = 1'b0;
        in_if.tdata   = '0;
        in_if.tkeep   = '0;
        in_if.tlast   = 1'b0;
        in_if.tuser   = 1'b0;
        hdr_if.ready  = 1'b0;
        pay_if.tready = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_in_tready", in_if.tready, 1);
        check("rst_hdr_valid", hdr_if.valid, 0);
        check("rst_hdr_length", hdr_if.length, 0);
        check("rst_hdr_dest_ip", hdr_if.dest_ip, 0);
        check("rst_pay_tvalid", pay_if.tvalid, 0);
        check("rst_pay_tlast", pay_if.tlast, 0);
        check("rst_pay_tuser", pay_if.tuser, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Basic 8-byte frame, ID 0, latency and throughput
        frame_a();
        send();
        check("t1_hdr_valid_after_close", hdr_if.valid, 1);
        check("t1_in_tready_after_close", in_if.tready, 0);
        recv(0, 1'b0);
        check("t1_length", r_len, 20);
        check("t1_src_port", r_sp, 8891);
        check("t1_dst_port", r_dp, 4321);
        check("t1_dest_ip", r_ip, 32'hC0A8_0164);
        check("t1_checksum", r_cs, 0);
        check("t1_first_byte_gap", r_gap, 1);
        check("t1_span_cycles", r_span, 12);
        check("t1_tuser", r_tuser, 0);
        exp_a(32'd0);
        check_payload("t1_payload", r_bytes);
        check("t1_in_tready_back", in_if.tready, 1);

        // Same frame again carries ID 1
        frame_a();
        send();
        recv(0, 1'b0);
        exp_a(32'd1);
        check_payload("t2_payload", r_bytes);

        // Partial last beat
        tx_q.delete();
        add_beat(32'h1413_1211, 4'hF, 1'b0, 1'b0);
        add_beat(32'hDEAD_BBAA, 4'b0011, 1'b1, 1'b0);
        send();
        recv(0, 1'b0);
        check("t3_length", r_len, 18);
        exp_id(32'd2);
        e_bytes.push_back(8'h11); e_bytes.push_back(8'h12);
        e_bytes.push_back(8'h13); e_bytes.push_back(8'h14);
        e_bytes.push_back(8'hAA); e_bytes.push_back(8'hBB);
        check_payload("t3_payload", r_bytes);

        // Bad frame (tuser on beat 2) is discarded, ID unchanged
        tx_q.delete();
        add_beat(32'h1111_1111, 4'hF, 1'b0, 1'b0);
        add_beat(32'h2222_2222, 4'hF, 1'b0, 1'b1);
        add_beat(32'h3333_3333, 4'hF, 1'b1, 1'b0);
        send();
        hv = 0;
        for (int i = 0; i < 100; i++) begin
            if (hdr_if.valid) hv++;
            @(negedge clk);
        end
        check("t4_bad_hdr_valid_cycles", hv, 0);
        check("t4_bad_in_tready", in_if.tready, 1);
        frame_a();
        send();
        recv(0, 1'b0);
        check("t4_next_length", r_len, 20);
        exp_a(32'd3);
        check_payload("t4_next_payload", r_bytes);

        // 1100-byte frame split at 1024 bytes
        tx_q.delete();
        for (int b = 0; b < 275; b++) begin
            add_beat({8'(4*b+3), 8'(4*b+2), 8'(4*b+1), 8'(4*b)}, 4'hF, (b == 274), 1'b0);
        end
        fork
            send();
            begin
                recv(0, 1'b0);
                len1 = r_len;
                q1_bytes = r_bytes;
                recv(0, 1'b0);
            end
        join
        check("t5_len_first", len1, 1036);
        exp_id(32'd4);
        for (int j = 0; j < 1024; j++) e_bytes.push_back(8'(j));
        check_payload("t5_payload_first", q1_bytes);
        check("t5_len_second", r_len, 88);
        exp_id(32'd5);
        for (int j = 1024; j < 1100; j++) e_bytes.push_back(8'(j));
        check_payload("t5_payload_second", r_bytes);

        // Backpressure: header ready late, payload ready toggling
        frame_a();
        send();
        recv(5, 1'b1);
        check("t6_length", r_len, 20);
        check("t6_hdr_unstable_cycles", r_unstable, 0);
        check("t6_in_tready_during_tx", r_inrdy, 0);
        exp_a(32'd6);
        check_payload("t6_payload", r_bytes);
        check("t6_in_tready_after", in_if.tready, 1);

        // Packet ID wrap
        force dut.packet_id_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.packet_id_q;
        frame_a();
        send();
        recv(0, 1'b0);
        exp_a(32'hFFFF_FFFF);
        check_payload("t7_payload_ffff", r_bytes);
        frame_a();
        send();
        recv(0, 1'b0);
        exp_a(32'd0);
        check_payload("t7_payload_wrap", r_bytes);

        // Reset mid-payload aborts the datagram
        frame_a();
        send();
        hdr_if.ready  = 1'b1;
        pay_if.tready = 1'b1;
        repeat (7) @(negedge clk);
        check("t8_mid_tvalid", pay_if.tvalid, 1);
        check("t8_mid_tdata", pay_if.tdata, 8'h03);
        reset_n = 1'b0;
        #1;
        check("t8_rst_tvalid", pay_if.tvalid, 0);
        check("t8_rst_tlast", pay_if.tlast, 0);
        check("t8_rst_hdr_valid", hdr_if.valid, 0);
        check("t8_rst_in_tready", in_if.tready, 1);
        @(negedge clk);
        hdr_if.ready  = 1'b0;
        pay_if.tready = 1'b0;
        reset_n       = 1'b1;
        @(negedge clk);
        frame_a();
        send();
        recv(0, 1'b0);
        check("t8_length", r_len, 20);
        exp_a(32'd0);
        check_payload("t8_payload_after_reset", r_bytes);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
